// File: rtl/mem_pipe.sv
// mem_pipe: single-port synchronous RAM with a valid/ready request port, per-lane write enables
// and a READ_LATENCY-deep read pipeline. Define MEMORY_CLEAR_EN to zero the array after every reset.
module mem_pipe #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int LANE_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_wr,
  input  logic [ADDR_WIDTH-1:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]              req_wdata,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   req_be,
  output logic                               rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic                               busy
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  armed_reg;
  logic                  clearing;
  logic                  accept;
  logic                  rd_accept;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [LANES-1:0]      wr_be;

  // Holds every handshake output low until one clean edge has passed after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_reg <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
    end
  end

`ifdef MEMORY_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg, clr_cnt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    clearing     = 1'b0;
    case (state_reg)
      S_CLEAR: begin
        if (armed_reg) begin
          clearing     = 1'b1;
          clr_cnt_next = clr_cnt_reg + ADDR_WIDTH'(1);
          if (&clr_cnt_reg) begin
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        state_next = S_RUN;
      end
    endcase
  end

  assign req_ready = armed_reg && (state_reg == S_RUN);
  assign wr_addr   = clearing ? clr_cnt_reg : req_addr;
  assign wr_data   = clearing ? '0 : req_wdata;
  assign wr_be     = clearing ? '1 : req_be;
`else
  assign clearing  = 1'b0;
  assign req_ready = armed_reg;
  assign wr_addr   = req_addr;
  assign wr_data   = req_wdata;
  assign wr_be     = req_be;
`endif

  assign busy      = clearing;
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_wr;
  assign wr_en     = clearing || (accept && req_wr);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  logic [READ_LATENCY-1:0] vld_reg;
  logic [DATA_WIDTH-1:0]   dat_reg [READ_LATENCY];

  // Stage 0 is the registered array read; data stages only move with a valid so the output holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_reg[0] <= 1'b0;
      dat_reg[0] <= '0;
    end else begin
      vld_reg[0] <= rd_accept;
      if (rd_accept) begin
        dat_reg[0] <= mem[req_addr];
      end
    end
  end

  generate
    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_reg[gi] <= 1'b0;
          dat_reg[gi] <= '0;
        end else begin
          vld_reg[gi] <= vld_reg[gi-1];
          if (vld_reg[gi-1]) begin
            dat_reg[gi] <= dat_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign rsp_valid = vld_reg[READ_LATENCY-1];
  assign rsp_rdata = dat_reg[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_pipe.sv
// Bench for mem_pipe: an 8-bit latency-1 instance and a 32-bit latency-3 instance share one request stream
// and are checked every cycle against a word-level model; honours MEMORY_CLEAR_EN when defined.
module tb_mem_pipe;

  localparam int LB = 3;
`ifdef MEMORY_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr    = 1'b0;
  logic [4:0]  req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be    = '0;

  logic        a_req_ready, a_rsp_valid, a_busy;
  logic [7:0]  a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_busy;
  logic [31:0] b_rsp_rdata;

  mem_pipe #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .LANE_WIDTH(8), .READ_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata[7:0]), .req_be(req_be[0]),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .busy(a_busy)
  );

  mem_pipe #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .LANE_WIDTH(8), .READ_LATENCY(LB)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word memory, cycles since reset release, and a ring of expected responses
  // keyed by the edge after which each response must be visible.
  logic [31:0] mdl_mem   [32];
  int          mdl_gen   [32];
  int          rst_gen   = 0;
  int          edge_cnt  = 0;
  int          cyc       = 0;
  bit          seen_rst  = 1'b0;
  bit          rst_edge  = 1'b0;
  int          slot_a_due [8];
  int          slot_a_gen [8];
  logic [31:0] slot_a_d   [8];
  int          slot_b_due [8];
  int          slot_b_gen [8];
  logic [31:0] slot_b_d   [8];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  function automatic bit mdl_ready();
    return seen_rst && (cyc >= 1 + (CLR ? 32 : 0));
  endfunction

  function automatic bit mdl_busy();
    return seen_rst && CLR && (cyc >= 1) && (cyc <= 32);
  endfunction

  function automatic logic [31:0] mdl_word(input logic [4:0] a);
    return (CLR && mdl_gen[a] != rst_gen) ? 32'h0 : mdl_mem[a];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = d[8*l +: 8];
    return r;
  endfunction

  function automatic bit due_a();
    return slot_a_due[edge_cnt % 8] == edge_cnt && slot_a_gen[edge_cnt % 8] == rst_gen;
  endfunction

  function automatic bit due_b();
    return slot_b_due[edge_cnt % 8] == edge_cnt && slot_b_gen[edge_cnt % 8] == rst_gen;
  endfunction

  function automatic logic [31:0] exp_a();
    return rst_edge ? 32'h0 : (due_a() ? {24'h0, slot_a_d[edge_cnt % 8][7:0]} : last_a);
  endfunction

  function automatic logic [31:0] exp_b();
    return rst_edge ? 32'h0 : (due_b() ? slot_b_d[edge_cnt % 8] : last_b);
  endfunction

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_edge <= !rst_n;
    if (!rst_n) begin
      seen_rst <= 1'b1;
      cyc      <= 0;
      rst_gen  <= rst_gen + 1;
    end else begin
      if (cyc < 1000) cyc <= cyc + 1;
      if (req_valid && mdl_ready()) begin
        if (req_wr) begin
          mdl_mem[req_addr] <= merge(mdl_word(req_addr), req_wdata, req_be);
          mdl_gen[req_addr] <= rst_gen;
        end else begin
          slot_a_due[(edge_cnt + 1) % 8]  <= edge_cnt + 1;
          slot_a_gen[(edge_cnt + 1) % 8]  <= rst_gen;
          slot_a_d[(edge_cnt + 1) % 8]    <= mdl_word(req_addr);
          slot_b_due[(edge_cnt + LB) % 8] <= edge_cnt + LB;
          slot_b_gen[(edge_cnt + LB) % 8] <= rst_gen;
          slot_b_d[(edge_cnt + LB) % 8]   <= mdl_word(req_addr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (seen_rst) begin
      chk("a_req_ready", 32'(a_req_ready), 32'(mdl_ready()));
      chk("b_req_ready", 32'(b_req_ready), 32'(mdl_ready()));
      chk("a_busy", 32'(a_busy), 32'(mdl_busy()));
      chk("b_busy", 32'(b_busy), 32'(mdl_busy()));
      chk("a_rsp_valid", 32'(a_rsp_valid), 32'(due_a()));
      chk("b_rsp_valid", 32'(b_rsp_valid), 32'(due_b()));
      chk("a_rsp_rdata", 32'(a_rsp_rdata), exp_a());
      chk("b_rsp_rdata", b_rsp_rdata, exp_b());
      last_a <= exp_a();
      last_b <= exp_b();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    step();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    req_valid = 1'b0;
    while (!(a_req_ready && b_req_ready) && n < 100) begin
      step();
      n++;
    end
    chk("wait_ready_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic count_busy(input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (a_busy) cnt++;
    end
    chk(name, 32'(cnt), CLR ? 32'd32 : 32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{wr: 1'b1, addr: 5'd3,  wdata: 32'h11223344, be: 4'hF,    exp: 32'h0};
    tbl[1] = '{wr: 1'b1, addr: 5'd3,  wdata: 32'hAABBCCDD, be: 4'b0101, exp: 32'h0};
    tbl[2] = '{wr: 1'b0, addr: 5'd3,  wdata: 32'h0,        be: 4'h0,    exp: 32'h11BB33DD};
    tbl[3] = '{wr: 1'b1, addr: 5'd7,  wdata: 32'h0000005A, be: 4'hF,    exp: 32'h0};
    tbl[4] = '{wr: 1'b0, addr: 5'd7,  wdata: 32'h0,        be: 4'h0,    exp: 32'h0000005A};
    tbl[5] = '{wr: 1'b1, addr: 5'd3,  wdata: 32'hFFFFFFFF, be: 4'h0,    exp: 32'h0};
    tbl[6] = '{wr: 1'b0, addr: 5'd3,  wdata: 32'h0,        be: 4'h0,    exp: 32'h11BB33DD};
    tbl[7] = '{wr: 1'b1, addr: 5'd31, wdata: 32'hDEADBEEF, be: 4'hF,    exp: 32'h0};
    tbl[8] = '{wr: 1'b1, addr: 5'd31, wdata: 32'h77000000, be: 4'b1000, exp: 32'h0};
    tbl[9] = '{wr: 1'b0, addr: 5'd31, wdata: 32'h0,        be: 4'h0,    exp: 32'h77ADBEEF};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready();

    // Full sweep: write k^A5, then read back-to-back with A's response right after each accept.
    for (int k = 0; k < 32; k++) issue(1'b1, 5'(k), 32'(k) ^ 32'hA5, 4'hF);
    for (int k = 0; k < 32; k++) begin
      issue(1'b0, 5'(k), 32'h0, 4'h0);
      chk("sweep_a_valid", 32'(a_rsp_valid), 32'd1);
      chk("sweep_a_data", 32'(a_rsp_rdata), (32'(k) ^ 32'hA5) & 32'hFF);
    end
    idle(4);

    // Four back-to-back reads through the 3-deep pipeline.
    for (int j = 0; j < 7; j++) begin
      if (j < 4) issue(1'b0, 5'(j), 32'h0, 4'h0);
      else idle(1);
      chk("pipe_b_valid", 32'(b_rsp_valid), 32'(j >= 2 && j <= 5));
      if (j >= 2 && j <= 5) chk("pipe_b_data", b_rsp_rdata, 32'(j - 2) ^ 32'hA5);
    end
    idle(2);

    // Directed table: lane enables, write-then-read hazard, empty byte enable.
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      if (!tbl[i].wr) begin
        chk("tbl_a_valid", 32'(a_rsp_valid), 32'd1);
        chk("tbl_a_data", 32'(a_rsp_rdata), tbl[i].exp & 32'hFF);
        idle(2);
        chk("tbl_b_valid", 32'(b_rsp_valid), 32'd1);
        chk("tbl_b_data", b_rsp_rdata, tbl[i].exp);
      end
    end
    idle(3);

    // Random traffic, checked by the per-cycle monitor.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      else issue(1'($urandom), 5'($urandom), $urandom, 4'($urandom));
    end
    idle(4);

    // Reset while a read is in flight: the latency-3 response must never appear.
    issue(1'b0, 5'd5, 32'h0, 4'h0);
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("flush_b_valid", 32'(b_rsp_valid), 32'd0);
      chk("flush_b_data", b_rsp_rdata, 32'h0);
      step();
    end
    wait_ready();

    // Fill with FF, reset: clear build zeroes everything, otherwise contents survive.
    for (int k = 0; k < 32; k++) issue(1'b1, 5'(k), 32'hFFFFFFFF, 4'hF);
    idle(2);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    count_busy("busy_cycles");
    wait_ready();
    for (int k = 0; k < 32; k++) begin
      issue(1'b0, 5'(k), 32'h0, 4'h0);
      chk("post_reset_a_data", 32'(a_rsp_rdata), CLR ? 32'h0 : 32'hFF);
    end
    idle(4);

    // Reset again part-way through the clear; the count must restart.
    issue(1'b1, 5'd9, 32'h12345678, 4'hF);
    idle(1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_busy("busy_cycles_restart");
    wait_ready();
    issue(1'b0, 5'd9, 32'h0, 4'h0);
    idle(LB + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
